mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multicycle control unit for the ARM-subset core. It generalises the single-cycle decoder into a registered Moore FSM with condition-code evaluation and a stored NZCV flags register. It sits between the instruction register and the shared-memory multicycle datapath. Each cycle it drives the mux selects, write strobes and ALU control for that datapath.

Parameters:
PC_REG, 15, register index treated as PC; a write to it also asserts pc_write.
RD_W, 4, width of rd field.
CNT_W, 32, width of performance counters (optional feature).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
cond  in  4  instruction cond field; stable from DECODE to FETCH.
op  in  2  instruction op field.
funct  in  6  funct[5]=I (immediate), funct[4:1]=cmd, funct[0]=S, or L for memory ops.
rd  in  RD_W  destination register.
alu_flags  in  4  live ALU NZCV, in order {N,Z,C,V}.
pc_write, ir_write, reg_w, mem_w  out  1  write strobes.
adr_src  out  1  0=PC, 1=ALU result register.
alu_src_a  out  2  00=reg A, 01=PC.
alu_src_b  out  2  00=reg B, 01=extended imm, 10=constant 4.
result_src  out  2  00=ALU out register, 01=read data, 10=ALU direct.
imm_src  out  2  00=8-bit dp, 01=12-bit mem, 10=24-bit branch.
reg_src  out  2  [0]=read R15 on port 1, [1]=read rd on port 2 (STR).
alu_control  out  3  000 add, 001 sub, 010 and, 011 orr, 100 eor.
perf_cycles  out  CNT_W  cycle counter.
perf_instret  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset (async): state=FETCH, flags=0000, counters=0. While reset is high, pc_write/ir_write/reg_w/mem_w are forced to 0; other outputs take their FETCH values.
- Outputs are Moore-decoded from state, except strobes gated by cond_ex and rd checks. Unlisted outputs are 0.
- FETCH: ir_write=1, pc_write=1, adr_src=0, a=01, b=10, add, result_src=10. Next state DECODE.
- DECODE: a=01, b=10, result_src=10; imm_src/reg_src from op. Next state:
  - op=01 -> MEMADR
  - op=00 with I=0 -> EXECR
  - op=00 with I=1 -> EXECI
  - op=10 -> BRANCH
  - op=11 -> FETCH (illegal; no writes)
- MEMADR: a=00, b=01, add. Next state MEMRD if L=1, else MEMWR.
- MEMRD: adr_src=1. Next state MEMWB.
- MEMWB: result_src=01, reg_w=cond_ex, pc_write=cond_ex&(rd==PC_REG). Next state FETCH.
- MEMWR: adr_src=1, mem_w=cond_ex. Next state FETCH.
- EXECR: a=00, b=00. EXECI: a=00, b=01. Both go to ALUWB.
- ALUWB: result_src=00, reg_w=cond_ex&legal&!(cmp|tst), pc_write=that&(rd==PC_REG). Next state FETCH.
- BRANCH: a=00 (R15=PC+8), b=01, add, result_src=10, pc_write=cond_ex. Next state FETCH.
- cmd decode (DP only; alu_control is add in all other states):
  - 0100 add -> 000
  - 0010 sub -> 001
  - 0000 and -> 010
  - 1100 orr -> 011
  - 0001 eor -> 100
  - 1010 cmp -> 001
  - 1000 tst -> 010
  - Any other cmd is illegal: alu add, no reg_w, no flag write.
- Flag write: on the edge leaving EXECR/EXECI, if cond_ex & legal & (S|cmp|tst).
  - N and Z are always loaded from alu_flags.
  - C and V are loaded only for add, sub and cmp.
- cond_ex is combinational from the stored flags:
  - 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC
  - 1000 HI (C&!Z), 1001 LS
  - 1010 GE (N==V), 1011 LT
  - 1100 GT (!Z&N==V), 1101 LE
  - 1110 AL = 1; 1111 = 0 (never executes).
- Latency in cycles: DP=4, LDR=5, STR=4, B=3, illegal=2.
- Flags updated by instruction k are visible to instruction k+1's cond_ex.

Optional Feature:
MC_CTRL_PERF_EN.
- Defined: perf_cycles increments every non-reset cycle. perf_instret increments on each transition into FETCH from any state other than FETCH, including condition-failed and illegal instructions. Both wrap modulo 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH)
  - ALU control codes
  - mux select codes
  - cond codes
  - cmd codes
- One sub-module, cond_check, holds the flags register, the flag-write enables and the cond_ex evaluation.

Test Plan:
- Reset asserted mid-MEMWR with cond=AL -> mem_w drops in the same cycle, state=FETCH, flags=0000; after release, the first cycle has ir_write=1 and pc_write=1.
- ADD reg: op=00, funct=001000, cond=1110, rd=3 -> FETCH, DECODE, EXECR (alu_control=000), ALUWB (reg_w=1, pc_write=0); 4 cycles total.
- CMP imm: funct=110101, alu_flags=0110 -> flags=0110, no reg_w. Then B with cond=0000 -> pc_write=1 in BRANCH; B with cond=0001 -> pc_write=0.
- LDR: op=01, funct=011001, rd=15 -> 5 cycles; MEMRD adr_src=1; MEMWB result_src=01, reg_w=1, pc_write=1.
- STR with cond=NE while Z=1 -> MEMWR has mem_w=0; back to FETCH after 4 cycles. Illegal cmd 0111 with S=1 -> no reg_w, flags unchanged.
- With MC_CTRL_PERF_EN: after ADD + LDR + B from reset -> perf_instret=3, perf_cycles=12.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state codes,
// ALU control codes, datapath mux select codes, condition and cmd codes.
package mc_ctrl_pkg;

   // FSM states
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;

   // ALU control codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;

   // Mux select codes
   localparam logic [1:0] SRCA_REG   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] IMM_DP     = 2'b00;
   localparam logic [1:0] IMM_MEM    = 2'b01;
   localparam logic [1:0] IMM_BR     = 2'b10;

   // Instruction op field
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Data-processing cmd codes
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Decoded view of a data-processing cmd
   typedef struct packed {
      logic       legal;   // cmd is one of the supported operations
      logic       cv_upd;  // C and V are meaningful (arithmetic ops)
      logic       no_wb;   // compare/test: flags only, never writes rd
      logic [2:0] alu;     // ALU control while executing
   } cmd_dec_t;

   function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
      cmd_dec_t d;
      d = '{legal: 1'b1, cv_upd: 1'b0, no_wb: 1'b0, alu: ALU_ADD};
      case (cmd)
         CMD_ADD: begin d.alu = ALU_ADD; d.cv_upd = 1'b1; end
         CMD_SUB: begin d.alu = ALU_SUB; d.cv_upd = 1'b1; end
         CMD_AND: d.alu = ALU_AND;
         CMD_ORR: d.alu = ALU_ORR;
         CMD_EOR: d.alu = ALU_EOR;
         CMD_CMP: begin d.alu = ALU_SUB; d.cv_upd = 1'b1; d.no_wb = 1'b1; end
         CMD_TST: begin d.alu = ALU_AND; d.no_wb = 1'b1; end
         default: begin d.legal = 1'b0; d.alu = ALU_ADD; end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mc_control_unit_cond_check.sv
// Condition check: stored NZCV flags, their write enables, and the
// condition-passed evaluation. Also keeps a copy of the condition result
// taken while executing, so the writeback cycle of an instruction sees its
// own pre-update condition even though it may have just rewritten the flags.
module cond_check
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic       exec_stage,
   input  logic       flag_req,
   input  logic       cv_req,
   output logic       cond_ex,
   output logic       cond_ex_held,
   output logic [3:0] flags
);

   logic nz_we;
   logic cv_we;

   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      logic r;
      {n, z, cf, v} = f;
      case (c)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = cf;
         COND_CC: r = ~cf;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = cf & ~z;
         COND_LS: r = ~(cf & ~z);
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = ~(~z & (n == v));
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   assign cond_ex = eval_cond(cond, flags);
   assign nz_we   = exec_stage & cond_ex & flag_req;
   assign cv_we   = nz_we & cv_req;

   // NZCV register: N/Z on any flag write, C/V only for arithmetic ops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (nz_we) flags[3:2] <= alu_flags[3:2];
         if (cv_we) flags[1:0] <= alu_flags[1:0];
      end
   end

   // Condition result captured on the execute edge, before flags change
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           cond_ex_held <= 1'b0;
      else if (exec_stage) cond_ex_held <= cond_ex;
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control unit: registered Moore FSM driving the shared-memory
// datapath selects, write strobes and ALU control, with condition checking
// against a stored NZCV register.
// Optional build macro MC_CTRL_PERF_EN adds cycle and retired-instruction
// counters; without it both perf ports are constant zero.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int PC_REG = 15,
   parameter int RD_W   = 4,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       cond,
   input  logic [1:0]       op,
   input  logic [5:0]       funct,
   input  logic [RD_W-1:0]  rd,
   input  logic [3:0]       alu_flags,
   output logic             pc_write,
   output logic             ir_write,
   output logic             reg_w,
   output logic             mem_w,
   output logic             adr_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic [1:0]       imm_src,
   output logic [1:0]       reg_src,
   output logic [2:0]       alu_control,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_instret
);

   logic [3:0] state;
   logic [3:0] next_state;
   cmd_dec_t   cmd_dec;
   logic       i_bit;
   logic       s_bit;
   logic       l_bit;
   logic       rd_is_pc;
   logic       exec_stage;
   logic       flag_req;
   logic       cond_ex;
   logic       cond_ex_held;
   logic [3:0] flags;
   logic       pc_write_raw;
   logic       ir_write_raw;
   logic       reg_w_raw;
   logic       mem_w_raw;

   assign i_bit      = funct[5];
   assign s_bit      = funct[0];
   assign l_bit      = funct[0];
   assign cmd_dec    = decode_cmd(funct[4:1]);
   assign rd_is_pc   = (rd == RD_W'(PC_REG));
   assign exec_stage = (state == S_EXECR) || (state == S_EXECI);
   assign flag_req   = cmd_dec.legal & (s_bit | cmd_dec.no_wb);

   cond_check u_cond (
      .clk          (clk),
      .reset        (reset),
      .cond         (cond),
      .alu_flags    (alu_flags),
      .exec_stage   (exec_stage),
      .flag_req     (flag_req),
      .cv_req       (cmd_dec.cv_upd),
      .cond_ex      (cond_ex),
      .cond_ex_held (cond_ex_held),
      .flags        (flags)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Next-state sequencing
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_MEM:  next_state = S_MEMADR;
               OP_DP:   next_state = i_bit ? S_EXECI : S_EXECR;
               OP_BR:   next_state = S_BRANCH;
               default: next_state = S_FETCH;
            endcase
         end
         S_MEMADR: next_state = l_bit ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state = S_MEMWB;
         S_EXECR:  next_state = S_ALUWB;
         S_EXECI:  next_state = S_ALUWB;
         default:  next_state = S_FETCH;
      endcase
   end

   // Moore output decode; strobes additionally gated by condition and rd
   always_comb begin
      pc_write_raw = 1'b0;
      ir_write_raw = 1'b0;
      reg_w_raw    = 1'b0;
      mem_w_raw    = 1'b0;
      adr_src      = 1'b0;
      alu_src_a    = SRCA_REG;
      alu_src_b    = SRCB_REG;
      result_src   = RES_ALUOUT;
      imm_src      = IMM_DP;
      reg_src      = 2'b00;
      alu_control  = ALU_ADD;
      case (state)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            alu_src_a    = SRCA_PC;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            case (op)
               OP_MEM: begin imm_src = IMM_MEM; reg_src = {~l_bit, 1'b0}; end
               OP_BR:  begin imm_src = IMM_BR;  reg_src = 2'b01; end
               default: begin imm_src = IMM_DP; reg_src = 2'b00; end
            endcase
         end
         S_MEMADR: begin
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src   = RES_RDATA;
            reg_w_raw    = cond_ex;
            pc_write_raw = cond_ex & rd_is_pc;
         end
         S_MEMWR: begin
            adr_src   = 1'b1;
            mem_w_raw = cond_ex;
         end
         S_EXECR: begin
            alu_control = cmd_dec.alu;
         end
         S_EXECI: begin
            alu_src_b   = SRCB_IMM;
            alu_control = cmd_dec.alu;
         end
         S_ALUWB: begin
            reg_w_raw    = cond_ex_held & cmd_dec.legal & ~cmd_dec.no_wb;
            pc_write_raw = cond_ex_held & cmd_dec.legal & ~cmd_dec.no_wb & rd_is_pc;
         end
         S_BRANCH: begin
            alu_src_b    = SRCB_IMM;
            result_src   = RES_ALU;
            pc_write_raw = cond_ex;
         end
         default: ;
      endcase
   end

   // No write strobe may escape while reset is held
   assign pc_write = pc_write_raw & ~reset;
   assign ir_write = ir_write_raw & ~reset;
   assign reg_w    = reg_w_raw & ~reset;
   assign mem_w    = mem_w_raw & ~reset;

`ifdef MC_CTRL_PERF_EN
   logic [CNT_W-1:0] cycles_q;
   logic [CNT_W-1:0] instret_q;

   // Free-running cycle count and retire count on every return to FETCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycles_q  <= '0;
         instret_q <= '0;
      end else begin
         cycles_q <= cycles_q + CNT_W'(1);
         if ((state != S_FETCH) && (next_state == S_FETCH))
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign perf_cycles  = cycles_q;
   assign perf_instret = instret_q;
`else
   assign perf_cycles  = '0;
   assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: expected per-cycle control words are
// queued as each instruction is issued and compared as the FSM steps.
module tb_mc_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;
   logic [3:0]  alu_flags;
   logic        pc_write, ir_write, reg_w, mem_w, adr_src;
   logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src, reg_src;
   logic [2:0]  alu_control;
   logic [31:0] perf_cycles, perf_instret;

   int passed = 0;
   int total  = 0;

   logic [17:0] exp_q[$];
   string       tag_q[$];

   mc_control_unit #(.PC_REG(15), .RD_W(4), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .alu_flags(alu_flags), .pc_write(pc_write), .ir_write(ir_write),
      .reg_w(reg_w), .mem_w(mem_w), .adr_src(adr_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
      .reg_src(reg_src), .alu_control(alu_control),
      .perf_cycles(perf_cycles), .perf_instret(perf_instret)
   );

   always #5 clk = ~clk;

   wire [17:0] obs = {pc_write, ir_write, reg_w, mem_w, adr_src, alu_src_a,
                      alu_src_b, result_src, imm_src, reg_src, alu_control};

   function automatic logic [17:0] cw(input logic pw, irw, rw, mw, adr,
                                      input logic [1:0] a, b, res, imm, rs,
                                      input logic [2:0] alu);
      return {pw, irw, rw, mw, adr, a, b, res, imm, rs, alu};
   endfunction

   function automatic logic [17:0] c_fetch();
      return cw(1, 1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000);
   endfunction
   function automatic logic [17:0] c_decode(input logic [1:0] imm, rs);
      return cw(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, imm, rs, 3'b000);
   endfunction
   function automatic logic [17:0] c_execr(input logic [2:0] alu);
      return cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, alu);
   endfunction
   function automatic logic [17:0] c_execi(input logic [2:0] alu);
      return cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, alu);
   endfunction
   function automatic logic [17:0] c_aluwb(input logic rw, pw);
      return cw(pw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
   endfunction
   function automatic logic [17:0] c_memadr();
      return cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
   endfunction
   function automatic logic [17:0] c_memrd();
      return cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
   endfunction
   function automatic logic [17:0] c_memwb(input logic rw, pw);
      return cw(pw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000);
   endfunction
   function automatic logic [17:0] c_memwr(input logic mw);
      return cw(0, 0, 0, mw, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
   endfunction
   function automatic logic [17:0] c_branch(input logic pw);
      return cw(pw, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) begin
         passed++;
      end else begin
         $error("FAIL %s: got %0h, expected %0h", tag, o, e);
      end
   endtask

   task automatic push(input string tag, input logic [17:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Drive one instruction (called just after an edge, in FETCH) and step
   // through all queued cycles, comparing each at the falling edge.
   task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] r, input logic [3:0] af);
      logic [17:0] e;
      string       t;
      cond = c; op = o; funct = f; rd = r; alu_flags = af;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk(t, 32'(obs), 32'(e));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic branch(input string tag, input logic [3:0] c, input logic taken);
      push({tag, "_fetch"}, c_fetch());
      push({tag, "_decode"}, c_decode(2'b10, 2'b01));
      push({tag, "_branch"}, c_branch(taken));
      run(c, 2'b10, 6'b100000, 4'd0, 4'b0000);
   endtask

   initial begin
      reset = 1'b1; cond = 4'b1110; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
      #12;
      chk("reset_outputs", 32'(obs), 32'(cw(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000)));
      chk("reset_flags", 32'(u_dut.u_cond.flags), 32'h0);
      chk("reset_cycles", perf_cycles, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // ADD r3 (register)
      push("add_fetch", c_fetch());
      push("add_decode", c_decode(2'b00, 2'b00));
      push("add_execr", c_execr(3'b000));
      push("add_aluwb", c_aluwb(1, 0));
      run(4'b1110, 2'b00, 6'b001000, 4'd3, 4'b0000);

      // LDR r15
      push("ldr_fetch", c_fetch());
      push("ldr_decode", c_decode(2'b01, 2'b00));
      push("ldr_memadr", c_memadr());
      push("ldr_memrd", c_memrd());
      push("ldr_memwb", c_memwb(1, 1));
      run(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);

      branch("b_al", 4'b1110, 1'b1);

`ifdef MC_CTRL_PERF_EN
      chk("perf_instret", perf_instret, 32'd3);
      chk("perf_cycles", perf_cycles, 32'd12);
`else
      chk("perf_instret_off", perf_instret, 32'd0);
      chk("perf_cycles_off", perf_cycles, 32'd0);
`endif

      // CMP immediate sets Z and C
      push("cmp_fetch", c_fetch());
      push("cmp_decode", c_decode(2'b00, 2'b00));
      push("cmp_execi", c_execi(3'b001));
      push("cmp_aluwb", c_aluwb(0, 0));
      run(4'b1110, 2'b00, 6'b110101, 4'd0, 4'b0110);
      chk("cmp_flags", 32'(u_dut.u_cond.flags), 32'h6);

      branch("beq_taken", 4'b0000, 1'b1);
      branch("bne_not", 4'b0001, 1'b0);

      // STR NE while Z=1: no memory write
      push("strne_fetch", c_fetch());
      push("strne_decode", c_decode(2'b01, 2'b10));
      push("strne_memadr", c_memadr());
      push("strne_memwr", c_memwr(0));
      run(4'b0001, 2'b01, 6'b011000, 4'd2, 4'b0000);

      // Illegal cmd 0111 with S=1: no writeback, flags untouched
      push("ill_fetch", c_fetch());
      push("ill_decode", c_decode(2'b00, 2'b00));
      push("ill_execr", c_execr(3'b000));
      push("ill_aluwb", c_aluwb(0, 0));
      run(4'b1110, 2'b00, 6'b001111, 4'd5, 4'b1001);
      chk("ill_flags", 32'(u_dut.u_cond.flags), 32'h6);

      // ORR immediate, EOR/AND/SUB register
      push("orr_fetch", c_fetch());
      push("orr_decode", c_decode(2'b00, 2'b00));
      push("orr_execi", c_execi(3'b011));
      push("orr_aluwb", c_aluwb(1, 0));
      run(4'b1110, 2'b00, 6'b111000, 4'd4, 4'b1111);
      push("eor_fetch", c_fetch());
      push("eor_decode", c_decode(2'b00, 2'b00));
      push("eor_execr", c_execr(3'b100));
      push("eor_aluwb", c_aluwb(1, 0));
      run(4'b1110, 2'b00, 6'b000010, 4'd6, 4'b1111);
      push("and_fetch", c_fetch());
      push("and_decode", c_decode(2'b00, 2'b00));
      push("and_execr", c_execr(3'b010));
      push("and_aluwb", c_aluwb(1, 0));
      run(4'b1110, 2'b00, 6'b000000, 4'd7, 4'b1111);
      push("sub_fetch", c_fetch());
      push("sub_decode", c_decode(2'b00, 2'b00));
      push("sub_execr", c_execr(3'b001));
      push("sub_aluwb", c_aluwb(1, 0));
      run(4'b1110, 2'b00, 6'b000100, 4'd8, 4'b1111);
      chk("s0_flags_kept", 32'(u_dut.u_cond.flags), 32'h6);

      // TST loads N,Z only: flags 0110 -> 1010
      push("tst_fetch", c_fetch());
      push("tst_decode", c_decode(2'b00, 2'b00));
      push("tst_execr", c_execr(3'b010));
      push("tst_aluwb", c_aluwb(0, 0));
      run(4'b1110, 2'b00, 6'b010001, 4'd0, 4'b1001);
      chk("tst_flags", 32'(u_dut.u_cond.flags), 32'hA);

      branch("bge_not", 4'b1010, 1'b0);
      branch("blt_taken", 4'b1011, 1'b1);
      branch("bhi_taken", 4'b1000, 1'b1);

      // ADDS MI to r15: passes on old flags, writes new flags 0100
      push("adds_fetch", c_fetch());
      push("adds_decode", c_decode(2'b00, 2'b00));
      push("adds_execr", c_execr(3'b000));
      push("adds_aluwb", c_aluwb(1, 1));
      run(4'b0100, 2'b00, 6'b001001, 4'd15, 4'b0100);
      chk("adds_flags", 32'(u_dut.u_cond.flags), 32'h4);
      branch("bmi_not", 4'b0100, 1'b0);
      branch("beq_taken2", 4'b0000, 1'b1);
      branch("bnv_not", 4'b1111, 1'b0);

      // Illegal op: two cycles, no writes
      push("op11_fetch", c_fetch());
      push("op11_decode", c_decode(2'b00, 2'b00));
      run(4'b1110, 2'b11, 6'b001000, 4'd1, 4'b0000);

      // STR AL interrupted by reset in MEMWR
      push("stral_fetch", c_fetch());
      push("stral_decode", c_decode(2'b01, 2'b10));
      push("stral_memadr", c_memadr());
      run(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000);
      @(negedge clk);
      chk("stral_memwr", 32'(obs), 32'(c_memwr(1)));
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_outputs", 32'(obs),
          32'(cw(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000)));
      chk("rst_mid_flags", 32'(u_dut.u_cond.flags), 32'h0);
      chk("rst_mid_instret", perf_instret, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_fetch", 32'(obs), 32'(c_fetch()));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
